// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: FSM state encoding, memory_unit func codes
// and default sizing.
package mem_arbiter_pkg;

   localparam int DEF_N      = 2;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Same encoding memory_unit decodes on its func input.
   localparam logic [1:0] MEM_FUNC_NOP   = 2'd0;
   localparam logic [1:0] MEM_FUNC_READ  = 2'd1;
   localparam logic [1:0] MEM_FUNC_WRITE = 2'd2;
   localparam logic [1:0] MEM_FUNC_ALLOC = 2'd3;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req scanning upward from ptr,
// wrapping mod N; returns one-hot winner and its index.
module rr_pick
   import mem_arbiter_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [N-1:0]  win_oh,
   output logic [IW-1:0] win_idx
);

   logic [N-1:0]  rot;
   logic [IW-1:0] off;
   logic [IW:0]   sum;

   // Rotating the doubled vector puts requester ptr at bit 0.
   assign rot = N'({req, req} >> ptr);
   assign any = |rot;

   always_comb begin
      off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) off = IW'(k);
      end
   end

   assign sum     = {1'b0, ptr} + {1'b0, off};
   assign win_idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
   assign win_oh  = any ? (N'(1) << win_idx) : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing the memory_unit port among N requesters.
// Optional MEM_ARBITER_LOCK_EN adds a lock input for atomic back-to-back ops.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req,
   input  logic [2*N-1:0]      req_func,
   input  logic [N*ADDR_W-1:0] req_addr,
   input  logic [N*DATA_W-1:0] req_wdata,
`ifdef MEM_ARBITER_LOCK_EN
   input  logic [N-1:0]        lock,
`endif
   output logic [N-1:0]        gnt,
   output logic [N-1:0]        ack,
   output logic [DATA_W-1:0]   rsp_data,
   output logic [1:0]          mem_func,
   output logic                mem_execute,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_write_data,
   input  logic [DATA_W-1:0]   mem_read_data,
   input  logic                mem_ready
);

   localparam int IW = idx_w(N);

   logic [1:0]        state;
   logic [IW-1:0]     rr_ptr, w_idx, pick_idx, sel_idx, rr_next;
   logic [N-1:0]      pick_oh;
   logic              pick_any, busy_seen, locked, lock_keep, go;
   logic [1:0]        lat_func;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req     (req),
      .ptr     (rr_ptr),
      .any     (pick_any),
      .win_oh  (pick_oh),
      .win_idx (pick_idx)
   );

`ifdef MEM_ARBITER_LOCK_EN
   assign lock_keep = lock[w_idx];
`else
   assign lock_keep = 1'b0;
`endif

   // A locked owner bypasses the scan and re-issues as soon as it asks again.
   assign sel_idx = locked ? w_idx : pick_idx;
   assign go      = mem_ready && (locked ? req[w_idx] : pick_any);
   assign rr_next = (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         w_idx     <= '0;
         gnt       <= '0;
         busy_seen <= 1'b0;
         locked    <= 1'b0;
         lat_func  <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (locked && !req[w_idx]) begin
                  locked <= 1'b0;
                  gnt    <= '0;
                  rr_ptr <= rr_next;
               end else if (go) begin
                  w_idx     <= sel_idx;
                  gnt       <= locked ? gnt : pick_oh;
                  lat_func  <= req_func[sel_idx*2 +: 2];
                  lat_addr  <= req_addr[sel_idx*ADDR_W +: ADDR_W];
                  lat_wdata <= req_wdata[sel_idx*DATA_W +: DATA_W];
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               busy_seen <= 1'b0;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // Completion only counts once memory has been seen busy.
               if (!mem_ready) begin
                  busy_seen <= 1'b1;
               end else if (busy_seen) begin
                  rsp_data <= mem_read_data;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               if (lock_keep) begin
                  locked <= 1'b1;
               end else begin
                  locked <= 1'b0;
                  gnt    <= '0;
                  rr_ptr <= rr_next;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_execute    = (state == ST_ISSUE);
   assign mem_func       = lat_func;
   assign mem_address    = lat_addr;
   assign mem_write_data = lat_wdata;
   assign ack            = (state == ST_DONE) ? gnt : '0;

endmodule
